// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: sequencer bus; req_* request in, resp_* result out, busy stall, mem_* byte memory port
interface mem_access_seq_if #(parameter int ADDR_W = 32);
  logic req_valid, req_ready, req_write, req_byte, req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic busy;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  modport slave (
    input req_valid, req_write, req_byte, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_byte, req_unsigned, req_addr, req_wdata, mem_rdata,
    input req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: byte/word load-store sequencer; clk, rst (async high), bus = request/response handshake + byte-wide memory port
module mem_access_seq #(parameter int ADDR_W = 32) (
  input logic clk,
  input logic rst,
  mem_access_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic write_q, byte_q, uns_q, last;
  logic [3:0][7:0] wdata_q, buf_q, buf_n;
  logic [31:0] rdata_q;
  // the final byte is folded in combinationally so the result can be registered on the edge entering DONE
  always_comb begin
    buf_n = buf_q;
    buf_n[cnt_q] = bus.mem_rdata;
  end
  assign last = byte_q ? cnt_q == 2'd0 : cnt_q == 2'd3;
  assign bus.req_ready = state_q == IDLE && !rst;
  assign bus.busy = state_q != IDLE;
  assign bus.resp_valid = state_q == DONE;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_addr = base_q + ADDR_W'(cnt_q);
  assign bus.mem_we = state_q == XFER && write_q;
  assign bus.mem_wdata = wdata_q[cnt_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      write_q <= 1'b0;
      byte_q <= 1'b0;
      uns_q <= 1'b0;
      wdata_q <= '0;
      buf_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q <= XFER;
          cnt_q <= '0;
          base_q <= bus.req_addr;
          write_q <= bus.req_write;
          byte_q <= bus.req_byte;
          uns_q <= bus.req_unsigned;
          wdata_q <= bus.req_wdata;
        end
        XFER: begin
          cnt_q <= cnt_q + 2'd1;
          if (!write_q) buf_q <= buf_n;
          if (last) state_q <= DONE;
          if (last && !write_q) rdata_q <= byte_q ? {{24{~uns_q & buf_n[0][7]}}, buf_n[0]} : buf_n;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven, directed and random checks of mem_access_seq against a transaction-level memory model
module tb_mem_access_seq;
  logic clk = 1'b0, rst = 1'b1, seed = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [31:0] last_rd, rd;
  int checks = 0, errors = 0;
  typedef struct {
    bit w, b, u;
    logic [31:0] a, d, exp;
  } vec_t;
  vec_t tbl [9];
  mem_access_seq_if #(.ADDR_W(32)) bus ();
  mem_access_seq #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk)
    if (seed) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] mb(input logic [31:0] a, input int k);
    return ref_mem[8'(a + 32'(k))];
  endfunction
  function automatic logic [31:0] model_load(input bit b, input bit u, input logic [31:0] a);
    if (!b) return {mb(a, 3), mb(a, 2), mb(a, 1), mb(a, 0)};
    if (u) return {24'h0, mb(a, 0)};
    return {{24{mb(a, 0) >= 8'h80}}, mb(a, 0)};
  endfunction
  task automatic chk_mem(input string n);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(n, 32'(bad), 32'd0);
  endtask
  task automatic do_req(input string n, input bit w, input bit b, input bit u, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    int cnt, lat, we_n, bad_seq, bad_st;
    cnt = b ? 1 : 4;
    lat = -1;
    we_n = 0;
    bad_seq = 0;
    bad_st = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte = b;
    bus.req_unsigned = u;
    bus.req_addr = a;
    bus.req_wdata = d;
    chk({n, " ready_before"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    {bus.req_write, bus.req_byte, bus.req_unsigned} = 3'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge clk);
      if (!bus.busy || bus.req_ready) bad_st++;
      if (bus.resp_valid) begin
        lat = k;
        if (bus.mem_we) bad_st++;
      end else begin
        if (bus.mem_we) we_n++;
        if (k < cnt && bus.mem_addr !== a + 32'(k)) bad_seq++;
        if (k < cnt && bus.mem_we && bus.mem_wdata !== d[8*k +: 8]) bad_seq++;
      end
    end
    chk({n, " resp_latency"}, 32'(lat), 32'(cnt));
    chk({n, " we_cycles"}, 32'(we_n), w ? 32'(cnt) : 32'd0);
    chk({n, " addr_data_seq"}, 32'(bad_seq), 32'd0);
    chk({n, " busy_ready"}, 32'(bad_st), 32'd0);
    r = bus.resp_rdata;
    @(negedge clk);
    chk({n, " idle_after"}, {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask
  task automatic run(input string n, input bit w, input bit b, input bit u, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    logic [31:0] exp;
    exp = w ? last_rd : model_load(b, u, a);
    do_req(n, w, b, u, a, d, r);
    chk({n, " rdata_model"}, r, exp);
    if (w) for (int k = 0; k < (b ? 1 : 4); k++) ref_mem[8'(a + 32'(k))] = d[8*k +: 8];
    last_rd = exp;
    chk_mem({n, " mem_model"});
  endtask
  initial begin
    int bad;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h3, 32'h00000080, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 32'hFFFFFF80};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h3, 32'h0, 32'h00000080};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h3, 32'h0, 32'hADBEEF80};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h9, 32'h12345678, 32'hADBEEF80};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'hADBEEF80};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h11223344};
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    last_rd = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    seed = 1'b0;
    @(negedge clk);
    chk("reset ctrl", {28'd0, bus.req_ready, bus.busy, bus.resp_valid, bus.mem_we}, 32'd0);
    chk("reset rdata", bus.resp_rdata, 32'd0);
    chk("reset addr", bus.mem_addr, 32'd0);
    chk("reset wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 9; i++) begin
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].b, tbl[i].u, tbl[i].a, tbl[i].d, rd);
      chk($sformatf("vec%0d rdata_table", i), rd, tbl[i].exp);
    end
    chk("byte store addr9", 32'(mem[9]), 32'h78);
    chk("byte store addr8 kept", 32'(mem[8]), 32'h52);
    chk("byte store addr10 kept", 32'(mem[10]), 32'h50);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_byte = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midstore we before reset", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("midstore reset ctrl", {28'd0, bus.req_ready, bus.busy, bus.resp_valid, bus.mem_we}, 32'd0);
    chk("midstore reset addr", bus.mem_addr, 32'd0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_we || bus.resp_valid) bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midstore ready after release", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      if (bus.resp_valid || bus.busy) bad++;
      @(negedge clk);
    end
    chk("midstore no resp", 32'(bad), 32'd0);
    chk("midstore bytes written", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'h4948C3D4);
    ref_mem[16'h10] = 8'hD4;
    ref_mem[16'h11] = 8'hC3;
    chk_mem("midstore mem_model");
    last_rd = 32'h0;
    chk("midstore rdata cleared", bus.resp_rdata, 32'h0);
    bad = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h20;
    @(posedge clk);
    #1;
    bus.req_byte = 1'b1;
    bus.req_addr = 32'hD0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.req_ready || !bus.busy) bad++;
      if (k < 4 && bus.mem_addr !== 32'h20 + 32'(k)) bad++;
      if (k == 4) chk("hs first result", bus.resp_rdata, model_load(1'b0, 1'b0, 32'h20));
      if (k == 4) chk("hs first resp", 32'(bus.resp_valid), 32'd1);
    end
    @(negedge clk);
    chk("hs idle gap", {30'd0, bus.busy, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_write = 1'b1;
    bus.req_byte = 1'b0;
    bus.req_addr = 32'h40;
    bus.req_wdata = 32'h0;
    @(negedge clk);
    chk("hs second addr", bus.mem_addr, 32'hD0);
    if (bus.req_ready || !bus.busy || bus.mem_we) bad++;
    @(negedge clk);
    chk("hs second resp", 32'(bus.resp_valid), 32'd1);
    chk("hs second result", bus.resp_rdata, 32'hFFFFFF8A);
    if (bus.req_ready || !bus.busy) bad++;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("hs final idle", {30'd0, bus.busy, bus.req_ready}, 32'd1);
    chk("hs busy_ready", 32'(bad), 32'd0);
    chk_mem("hs mem_model");
    last_rd = 32'hFFFFFF8A;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3)) : $urandom;
      run($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
